// File: rtl/tetris_pkg.sv
// Shared types and defaults for the falling-piece control blocks.
package tetris_pkg;

  localparam int unsigned BASE_TICKS_DEF = 10;
  localparam int unsigned MIN_TICKS_DEF  = 1;
  localparam int unsigned LOCK_TICKS_DEF = 2;
  localparam int unsigned LVL_W_DEF      = 4;
  localparam int unsigned CNT_W_DEF      = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_REQ      = 3'd2,
    S_LOCK     = 3'd3,
    S_LOCK_REQ = 3'd4,
    S_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/interval_calc.sv
// Drop interval in ticks: 1 under soft drop, else BASE_TICKS-level floored at MIN_TICKS.
module interval_calc
  import tetris_pkg::*;
#(
  parameter int unsigned BASE_TICKS = BASE_TICKS_DEF,
  parameter int unsigned MIN_TICKS  = MIN_TICKS_DEF,
  parameter int unsigned LVL_W      = LVL_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic [LVL_W-1:0] level,
  input  logic             soft_drop,
  output logic [CNT_W-1:0] interval_c
);

  localparam int unsigned DW = CNT_W + 1;

  logic [DW-1:0] diff_c;

  // One extra bit so level > BASE_TICKS shows up as a set sign bit, not a wrap.
  always_comb begin
    diff_c = DW'(BASE_TICKS) - DW'(level);
    if (soft_drop) begin
      interval_c = CNT_W'(1);
    end else if (diff_c[DW-1] || (diff_c < DW'(MIN_TICKS))) begin
      interval_c = CNT_W'(MIN_TICKS);
    end else begin
      interval_c = diff_c[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/drop_scheduler.sv
// Gravity scheduler: counts ticks to the next drop, handshakes drop/lock
// requests with the game-board FSM and runs the lock delay once landed.
module drop_scheduler
  import tetris_pkg::*;
#(
  parameter int unsigned BASE_TICKS = BASE_TICKS_DEF,
  parameter int unsigned MIN_TICKS  = MIN_TICKS_DEF,
  parameter int unsigned LOCK_TICKS = LOCK_TICKS_DEF,
  parameter int unsigned LVL_W      = LVL_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             active,
  input  logic             pause,
  input  logic             soft_drop,
  input  logic [LVL_W-1:0] level,
  input  logic             landed,
  input  logic             drop_ack,
  input  logic             lock_ack,
  output logic             drop_req,
  output logic             lock_req,
  output logic [2:0]       state_o
);

  localparam int unsigned XW = CNT_W + 1;

  logic [CNT_W-1:0] interval_c;

  interval_calc #(
    .BASE_TICKS (BASE_TICKS),
    .MIN_TICKS  (MIN_TICKS),
    .LVL_W      (LVL_W),
    .CNT_W      (CNT_W)
  ) u_interval_calc (
    .level      (level),
    .soft_drop  (soft_drop),
    .interval_c (interval_c)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             drop_req_q, drop_req_d;
  logic             lock_req_q, lock_req_d;

  logic          tick_run_c;
  logic [XW-1:0] cnt_inc_c;
  logic [XW-1:0] lcnt_inc_c;

  assign tick_run_c = tick && !pause;
  assign cnt_inc_c  = XW'(cnt_q) + XW'(1);
  assign lcnt_inc_c = XW'(lcnt_q) + XW'(1);

  // Next state and counters; requests are decoded from the next state so they
  // leave the flops already aligned with state_o.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcnt_d  = lcnt_q;

    if (!active) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      lcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (tick_run_c) begin
            if (cnt_inc_c >= XW'(interval_c)) begin
              cnt_d = '0;
              if (landed) begin
                state_d = S_LOCK;
                lcnt_d  = '0;
              end else begin
                state_d = S_REQ;
              end
            end else begin
              cnt_d = cnt_inc_c[CNT_W-1:0];
            end
          end
        end
        S_REQ: begin
          if (drop_ack) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
        S_LOCK: begin
          // Sliding off an edge beats any tick in the same cycle.
          if (!landed) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            lcnt_d  = '0;
          end else if (tick_run_c) begin
            if (lcnt_inc_c == XW'(LOCK_TICKS)) begin
              state_d = S_LOCK_REQ;
            end else begin
              lcnt_d = lcnt_inc_c[CNT_W-1:0];
            end
          end
        end
        S_LOCK_REQ: begin
          if (lock_ack) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    drop_req_d = (state_d == S_REQ);
    lock_req_d = (state_d == S_LOCK_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lcnt_q     <= '0;
      drop_req_q <= 1'b0;
      lock_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lcnt_q     <= lcnt_d;
      drop_req_q <= drop_req_d;
      lock_req_q <= lock_req_d;
    end
  end

  assign drop_req = drop_req_q;
  assign lock_req = lock_req_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler: a per-cycle vector table plus scripted
// sequences for drop timing, lock delay, slide-off, pause and async reset.
module tb_drop_scheduler;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       active;
  logic       pause;
  logic       soft_drop;
  logic [3:0] level;
  logic       landed;
  logic       drop_ack;
  logic       lock_ack;
  logic       drop_req;
  logic       lock_req;
  logic [2:0] state_o;

  int checks;
  int passes;

  drop_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .active    (active),
    .pause     (pause),
    .soft_drop (soft_drop),
    .level     (level),
    .landed    (landed),
    .drop_ack  (drop_ack),
    .lock_ack  (lock_ack),
    .drop_req  (drop_req),
    .lock_req  (lock_req),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic       active;
    logic       landed;
    logic       soft_drop;
    logic       pause;
    logic [3:0] level;
    logic       tick;
    logic       drop_ack;
    logic       lock_ack;
    logic       exp_drop;
    logic       exp_lock;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Pulse inputs for exactly one rising edge, then sample 1 ns after it.
  task automatic cyc(input logic t, input logic da, input logic la);
    tick     = t;
    drop_ack = da;
    lock_ack = la;
    @(posedge clk);
    #1;
    tick     = 1'b0;
    drop_ack = 1'b0;
    lock_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_out(input string name, input int d, input int l, input int s);
    check({name, ".drop_req"}, int'(drop_req), d);
    check({name, ".lock_req"}, int'(lock_req), l);
    check({name, ".state"}, int'(state_o), s);
  endtask

  initial begin
    checks = 0; passes = 0;
    rst = 1'b0; tick = 1'b0; active = 1'b0; pause = 1'b0; soft_drop = 1'b0;
    level = 4'd0; landed = 1'b0; drop_ack = 1'b0; lock_ack = 1'b0;

    //            act lnd sft pse lvl tk  dak lak  dr lr st
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,4'd12,1'b0,1'b0,1'b0, 1'b0,1'b0,3'd1};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,4'd12,1'b1,1'b0,1'b0, 1'b1,1'b0,3'd2};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,4'd12,1'b1,1'b0,1'b0, 1'b1,1'b0,3'd2};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,4'd12,1'b1,1'b0,1'b0, 1'b1,1'b0,3'd2};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,4'd12,1'b1,1'b1,1'b0, 1'b0,1'b0,3'd1};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,4'd12,1'b0,1'b0,1'b0, 1'b0,1'b0,3'd1};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,4'd12,1'b1,1'b0,1'b0, 1'b1,1'b0,3'd2};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,4'd12,1'b0,1'b1,1'b0, 1'b0,1'b0,3'd1};
    vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,4'd0, 1'b1,1'b0,1'b0, 1'b1,1'b0,3'd2};
    vecs[9]  = '{1'b1,1'b0,1'b1,1'b0,4'd0, 1'b0,1'b1,1'b0, 1'b0,1'b0,3'd1};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 1'b1,1'b0,1'b0, 1'b0,1'b0,3'd1};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,1'b1, 1'b0,1'b0,3'd1};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b1,1'b0, 1'b0,1'b0,3'd1};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,3'd0};

    // Reset values
    #35;
    chk_out("reset", 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Table: saturated level, ticks discarded in REQ, soft drop, stray acks
    for (int i = 0; i < 14; i++) begin
      active    = vecs[i].active;
      landed    = vecs[i].landed;
      soft_drop = vecs[i].soft_drop;
      pause     = vecs[i].pause;
      level     = vecs[i].level;
      cyc(vecs[i].tick, vecs[i].drop_ack, vecs[i].lock_ack);
      chk_out($sformatf("vec%0d", i), int'(vecs[i].exp_drop),
              int'(vecs[i].exp_lock), int'(vecs[i].exp_state));
    end

    // Level 0: ten ticks to a drop, request held until ack
    active = 1'b1; level = 4'd0; landed = 1'b0; soft_drop = 1'b0; pause = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check("lvl0.enter_wait", int'(state_o), 1);
    ticks(9);
    check("lvl0.tick9", int'(drop_req), 0);
    ticks(1);
    chk_out("lvl0.tick10", 1, 0, 2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check($sformatf("lvl0.hold%0d", i), int'(drop_req), 1);
    end
    cyc(1'b0, 1'b1, 1'b0);
    chk_out("lvl0.ack", 0, 0, 1);
    ticks(9);
    check("lvl0.cnt_cleared", int'(state_o), 1);
    ticks(1);
    chk_out("lvl0.second_drop", 1, 0, 2);

    // Asynchronous reset between clock edges while requesting
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst.drop_req", int'(drop_req), 0);
    check("async_rst.state", int'(state_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("after_rst.wait", int'(state_o), 1);

    // Landed at expiry: lock delay, lock request, done, new piece
    level = 4'd8; landed = 1'b1;
    ticks(2);
    chk_out("lock.enter", 0, 0, 3);
    ticks(1);
    chk_out("lock.lcnt1", 0, 0, 3);
    ticks(1);
    chk_out("lock.req", 0, 1, 4);
    cyc(1'b0, 1'b0, 1'b0);
    check("lock.req_hold", int'(lock_req), 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk_out("lock.done", 0, 0, 5);
    ticks(1);
    check("lock.done_hold", int'(state_o), 5);
    active = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check("lock.idle", int'(state_o), 0);
    active = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("lock.new_piece", int'(state_o), 1);

    // Slide off while locking, coincident with a tick
    ticks(2);
    check("slide.lock", int'(state_o), 3);
    ticks(1);
    landed = 1'b0;
    ticks(1);
    chk_out("slide.wait", 0, 0, 1);
    level = 4'd0;
    ticks(9);
    check("slide.tick9", int'(drop_req), 0);
    ticks(1);
    chk_out("slide.drop", 1, 0, 2);
    cyc(1'b0, 1'b1, 1'b0);

    // Pause freezes the interval count; held request survives pause
    ticks(4);
    pause = 1'b1;
    ticks(20);
    chk_out("pause.frozen", 0, 0, 1);
    pause = 1'b0;
    ticks(5);
    check("pause.tick5", int'(drop_req), 0);
    ticks(1);
    chk_out("pause.drop", 1, 0, 2);
    pause = 1'b1;
    ticks(1);
    check("pause.req_held", int'(drop_req), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk_out("pause.ack_taken", 0, 0, 1);
    pause = 1'b0; level = 4'd12;
    ticks(1);
    check("withdraw.req", int'(drop_req), 1);
    active = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk_out("withdraw.idle", 0, 0, 0);

    // Interval shrinking below the running count fires on the next tick
    active = 1'b1; level = 4'd0;
    cyc(1'b0, 1'b0, 1'b0);
    ticks(5);
    check("shrink.before", int'(state_o), 1);
    level = 4'd12;
    ticks(1);
    chk_out("shrink.fire", 1, 0, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
